// File: rtl/led_seq_ctrl.sv
// LED sequencing controller: drives the tick counter (enable/clear/rate) and
// turns its valid pulses into LED patterns. Optional macro: LED_PINGPONG_EN.
//
//   state | meaning
//   IDLE  | stopped, o_led holds, waiting for run switch
//   LOAD  | one cycle: clear tick counter, load mode's initial pattern
//   RUN   | counter enabled, each tick advances the pattern
module led_seq_ctrl #(
  parameter int NB_LEDS = 4,
  parameter int NB_SW   = 3,
  parameter int NB_BTN  = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [NB_BTN-1:0]  i_btn,
  output logic [NB_LEDS-1:0] o_led,
  output logic [1:0]         o_mode,
  output logic               o_count_en,
  output logic               o_count_clr,
  output logic [1:0]         o_rate
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [1:0] MODE_SHL   = 2'd0;
  localparam logic [1:0] MODE_SHR   = 2'd1;
  localparam logic [1:0] MODE_FLASH = 2'd2;
`ifdef LED_PINGPONG_EN
  localparam logic [1:0] MODE_PP    = 2'd3;
  localparam int         MODE_BTNS  = 4;
`else
  localparam int         MODE_BTNS  = 3;
`endif

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [NB_BTN-1:0]  btn_prev;
  logic [NB_BTN-1:0]  btn_mask;
  logic [NB_BTN-1:0]  btn_edge;
  logic               any_edge;
  logic [1:0]         edge_mode;
  logic               reload_pend;
  logic               run_sw;
  logic               led_zero;
  logic [NB_LEDS-1:0] led_init;
  logic [NB_LEDS-1:0] led_step;
  logic [NB_LEDS-1:0] led_shl0;
  logic [NB_LEDS-1:0] led_shr0;

  assign run_sw   = i_sw[0];
  assign led_zero = (o_led == '0);
  assign led_shl0 = {o_led[NB_LEDS-2:0], 1'b0};
  assign led_shr0 = {1'b0, o_led[NB_LEDS-1:1]};

  // Buttons beyond the available modes never produce an edge.
  always_comb begin
    btn_mask = '0;
    for (int i = 0; i < NB_BTN; i++) begin
      btn_mask[i] = (i < MODE_BTNS);
    end
  end

  assign btn_edge = i_btn & ~btn_prev & btn_mask;
  assign any_edge = |btn_edge;

  // Scan from the top so the lowest-index edge is the last one assigned.
  always_comb begin
    edge_mode = MODE_SHL;
    for (int i = NB_BTN - 1; i >= 0; i--) begin
      if (btn_edge[i]) begin
        edge_mode = 2'(i);
      end
    end
  end

  always_comb begin
    led_init = {{(NB_LEDS-1){1'b0}}, 1'b1};
    case (o_mode)
      MODE_SHR:   led_init = {1'b1, {(NB_LEDS-1){1'b0}}};
      MODE_FLASH: led_init = '1;
      default:    led_init = {{(NB_LEDS-1){1'b0}}, 1'b1};
    endcase
  end

`ifdef LED_PINGPONG_EN
  logic pp_dir;
  logic pp_dir_step;
`endif

  always_comb begin
    led_step = o_led;
`ifdef LED_PINGPONG_EN
    pp_dir_step = pp_dir;
`endif
    case (o_mode)
      MODE_SHL:   led_step = {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
      MODE_SHR:   led_step = {o_led[0], o_led[NB_LEDS-1:1]};
      MODE_FLASH: led_step = ~o_led;
`ifdef LED_PINGPONG_EN
      MODE_PP: begin
        // pp_dir: 0 = moving left, 1 = moving right; bounce at the ends.
        if (!pp_dir && o_led[NB_LEDS-1]) begin
          pp_dir_step = 1'b1;
          led_step    = led_shr0;
        end else if (pp_dir && o_led[0]) begin
          pp_dir_step = 1'b0;
          led_step    = led_shl0;
        end else begin
          led_step = pp_dir ? led_shr0 : led_shl0;
        end
      end
`endif
      default:    led_step = o_led;
    endcase
  end

`ifndef LED_PINGPONG_EN
  logic unused_shift;
  assign unused_shift = ^{led_shl0, led_shr0};
`endif

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (run_sw) begin
          state_next = (reload_pend || led_zero || any_edge) ? ST_LOAD : ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD: state_next = any_edge ? ST_LOAD : ST_RUN;
      ST_RUN: begin
        if (!run_sw) begin
          state_next = ST_IDLE;
        end else if (any_edge) begin
          state_next = ST_LOAD;
        end else begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      btn_prev    <= '0;
      reload_pend <= 1'b1;
      o_led       <= '0;
      o_mode      <= MODE_SHL;
      o_rate      <= 2'b00;
`ifdef LED_PINGPONG_EN
      pp_dir      <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      btn_prev <= i_btn;
      o_rate   <= i_sw[2:1];
      if (any_edge) begin
        o_mode <= edge_mode;
      end
      case (state)
        ST_LOAD: begin
          o_led       <= led_init;
          reload_pend <= 1'b0;
`ifdef LED_PINGPONG_EN
          pp_dir      <= 1'b0;
`endif
        end
        ST_RUN: begin
          if (any_edge) begin
            reload_pend <= 1'b1;
          end
          if (run_sw && !any_edge && i_valid) begin
            o_led  <= led_step;
`ifdef LED_PINGPONG_EN
            pp_dir <= pp_dir_step;
`endif
          end
        end
        default: begin
          if (any_edge) begin
            reload_pend <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_count_en  = (state == ST_RUN);
  assign o_count_clr = (state == ST_LOAD);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl (NB_LEDS=4); covers the pingpong mode when
// LED_PINGPONG_EN is defined and the ignored-button behaviour otherwise.
module tb_led_seq_ctrl;
  logic       clock;
  logic       i_reset;
  logic       i_valid;
  logic [2:0] i_sw;
  logic [3:0] i_btn;
  logic [3:0] o_led;
  logic [1:0] o_mode;
  logic       o_count_en;
  logic       o_count_clr;
  logic [1:0] o_rate;

  int checks = 0;
  int passes = 0;

  led_seq_ctrl #(.NB_LEDS(4), .NB_SW(3), .NB_BTN(4)) dut (
    .clock(clock),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_sw(i_sw),
    .i_btn(i_btn),
    .o_led(o_led),
    .o_mode(o_mode),
    .o_count_en(o_count_en),
    .o_count_clr(o_count_clr),
    .o_rate(o_rate)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Idle gap, then a one-cycle valid pulse; returns just after the edge that used it.
  task automatic tick();
    repeat (7) cyc();
    i_valid = 1'b1;
    cyc();
    i_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    i_btn = b;
    cyc();
    i_btn = 4'b0000;
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_sw    = 3'b000;
    i_btn   = 4'b0000;
    #12;
    chk("rst_led", o_led, 4'b0000);
    chk("rst_mode", o_mode, 2'b00);
    chk("rst_en", o_count_en, 1'b0);
    chk("rst_clr", o_count_clr, 1'b0);
    chk("rst_rate", o_rate, 2'b00);
    cyc();
    i_reset = 1'b0;
    cyc();

    // start from reset: LOAD one cycle, then SHL rotation
    i_sw = 3'b001;
    cyc();
    chk("start_clr", o_count_clr, 1'b1);
    chk("start_en", o_count_en, 1'b0);
    cyc();
    chk("start_clr_off", o_count_clr, 1'b0);
    chk("start_en_on", o_count_en, 1'b1);
    chk("shl_init", o_led, 4'b0001);
    tick(); chk("shl_t1", o_led, 4'b0010);
    tick(); chk("shl_t2", o_led, 4'b0100);
    tick(); chk("shl_t3", o_led, 4'b1000);
    tick(); chk("shl_wrap", o_led, 4'b0001);
    chk("shl_en", o_count_en, 1'b1);
    tick(); tick(); chk("shl_at_0100", o_led, 4'b0100);

    // btn[1] -> SHR
    press(4'b0010);
    chk("shr_mode", o_mode, 2'b01);
    chk("shr_load", o_count_clr, 1'b1);
    chk("shr_hold", o_led, 4'b0100);
    cyc();
    chk("shr_init", o_led, 4'b1000);
    tick(); chk("shr_t1", o_led, 4'b0100);
    tick(); chk("shr_t2", o_led, 4'b0010);
    tick(); chk("shr_t3", o_led, 4'b0001);
    tick(); chk("shr_wrap", o_led, 4'b1000);

    // btn[2] -> FLASH, stop at 0000, restart reloads
    press(4'b0100);
    chk("fl_mode", o_mode, 2'b10);
    cyc();
    chk("fl_init", o_led, 4'b1111);
    tick(); chk("fl_t1", o_led, 4'b0000);
    tick(); chk("fl_t2", o_led, 4'b1111);
    tick(); chk("fl_t3", o_led, 4'b0000);
    i_sw = 3'b000;
    cyc();
    chk("stop_en", o_count_en, 1'b0);
    repeat (3) cyc();
    chk("idle_hold0", o_led, 4'b0000);
    i_sw = 3'b001;
    cyc();
    chk("zero_reload", o_count_clr, 1'b1);
    cyc();
    chk("fl_restart", o_led, 4'b1111);

    // stop with nonzero pattern, resume goes straight to RUN
    i_sw = 3'b000;
    cyc();
    i_sw = 3'b001;
    cyc();
    chk("resume_clr", o_count_clr, 1'b0);
    chk("resume_en", o_count_en, 1'b1);
    chk("resume_led", o_led, 4'b1111);

    // button in IDLE sets reload
    i_sw = 3'b000;
    cyc();
    press(4'b0001);
    chk("idle_btn_mode", o_mode, 2'b00);
    chk("idle_btn_en", o_count_en, 1'b0);
    chk("idle_btn_led", o_led, 4'b1111);
    i_sw = 3'b001;
    cyc();
    chk("idle_btn_load", o_count_clr, 1'b1);
    cyc();
    chk("idle_btn_init", o_led, 4'b0001);

    // button beats tick in the same RUN cycle
    tick(); chk("pre_drop", o_led, 4'b0010);
    repeat (3) cyc();
    i_valid = 1'b1;
    press(4'b0001);
    i_valid = 1'b0;
    chk("drop_led", o_led, 4'b0010);
    chk("drop_load", o_count_clr, 1'b1);
    cyc();
    chk("drop_init", o_led, 4'b0001);

    // simultaneous btn[0] and btn[2]: lowest index wins
    press(4'b0010);
    cyc();
    chk("pri_pre", o_mode, 2'b01);
    press(4'b0101);
    chk("pri_mode", o_mode, 2'b00);
    cyc();
    chk("pri_init", o_led, 4'b0001);

    // stop beats button
    i_sw = 3'b000;
    press(4'b0010);
    chk("stop_pri_en", o_count_en, 1'b0);
    chk("stop_pri_clr", o_count_clr, 1'b0);
    chk("stop_pri_mode", o_mode, 2'b01);
    press(4'b0001);
    i_sw = 3'b001;
    cyc();
    cyc();
    chk("back_shl", o_led, 4'b0001);

`ifdef LED_PINGPONG_EN
    press(4'b1000);
    chk("pp_mode", o_mode, 2'b11);
    chk("pp_load", o_count_clr, 1'b1);
    cyc();
    chk("pp_init", o_led, 4'b0001);
    tick(); chk("pp_t1", o_led, 4'b0010);
    tick(); chk("pp_t2", o_led, 4'b0100);
    tick(); chk("pp_t3", o_led, 4'b1000);
    tick(); chk("pp_t4", o_led, 4'b0100);
    tick(); chk("pp_t5", o_led, 4'b0010);
    tick(); chk("pp_t6", o_led, 4'b0001);
    tick(); chk("pp_t7", o_led, 4'b0010);
    tick(); chk("pp_t8", o_led, 4'b0100);
`else
    press(4'b1000);
    chk("nopp_mode", o_mode, 2'b00);
    chk("nopp_clr", o_count_clr, 1'b0);
    chk("nopp_en", o_count_en, 1'b1);
    cyc();
    chk("nopp_led", o_led, 4'b0001);
    tick(); chk("nopp_t1", o_led, 4'b0010);
`endif

    // async reset mid-RUN, rate follows switches after release
    i_sw = 3'b101;
    cyc();
    chk("rate_pre", o_rate, 2'b10);
    #3;
    i_reset = 1'b1;
    #1;
    chk("arst_led", o_led, 4'b0000);
    chk("arst_mode", o_mode, 2'b00);
    chk("arst_en", o_count_en, 1'b0);
    chk("arst_rate", o_rate, 2'b00);
    cyc();
    chk("arst_hold_rate", o_rate, 2'b00);
    i_reset = 1'b0;
    cyc();
    chk("rate_after", o_rate, 2'b10);
    chk("post_rst_load", o_count_clr, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
